ezpz_bist_driver: RTL and testbench

- Sequential stimulus/response engine for the small combinational gate-level benchmark circuits: 10 primary inputs, 1 primary output.
- Drives the circuit's input vector from an exhaustive counter or an LFSR, and compacts the circuit's single output into a MISR signature plus a ones count.
- At end of run, compares the signature against an expected value.
- Serves as the on-chip other end of the benchmark netlist's interface, for equivalence checks of pre- and post-synthesis netlists.

---
 rtl/ezpz_bist_driver_pkg.sv | 17 +
 rtl/ezpz_misr.sv | 32 +++
 rtl/ezpz_bist_driver.sv | 156 +++++++++++++++
 tb/tb_ezpz_bist_driver.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ezpz_bist_driver_pkg.sv
// rtl/ezpz_bist_driver_pkg.sv - shared types and constants for the BIST driver
package ezpz_bist_driver_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [9:0]  DEF_LFSR_TAPS = 10'h240;
   localparam logic [15:0] DEF_MISR_POLY = 16'h1021;

   localparam logic MODE_EXH  = 1'b0;
   localparam logic MODE_LFSR = 1'b1;

endpackage

// File: rtl/ezpz_misr.sv
// rtl/ezpz_misr.sv - single-input MISR; sig_nxt exposes the value the next enabled edge will load
module ezpz_misr
   import ezpz_bist_driver_pkg::*;
#(
   parameter int              SIG_W     = 16,
   parameter logic [SIG_W-1:0] MISR_POLY = DEF_MISR_POLY
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   input  logic             din,
   output logic [SIG_W-1:0] sig,
   output logic [SIG_W-1:0] sig_nxt
);

   always_comb begin
      sig_nxt = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : '0);
      sig_nxt[0] = sig_nxt[0] ^ din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig <= '0;
      end else if (clear) begin
         sig <= '0;
      end else if (enable) begin
         sig <= sig_nxt;
      end
   end

endmodule

// File: rtl/ezpz_bist_driver.sv
// rtl/ezpz_bist_driver.sv - exhaustive/LFSR stimulus engine with MISR + ones-count compaction
module ezpz_bist_driver
   import ezpz_bist_driver_pkg::*;
#(
   parameter int               IN_W      = 10,
   parameter int               SIG_W     = 16,
   parameter logic [IN_W-1:0]  LFSR_TAPS = DEF_LFSR_TAPS,
   parameter logic [SIG_W-1:0] MISR_POLY = DEF_MISR_POLY,
   parameter int               RESP_LAT  = 0
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             mode,
   input  logic [IN_W-1:0]  seed,
   input  logic [15:0]      pat_count,
   input  logic [SIG_W-1:0] exp_sig,
   output logic [IN_W-1:0]  dut_in,
   input  logic             dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature,
   output logic [15:0]      ones_cnt
);

   localparam logic [15:0] FULL_EXH   = 16'(1 << IN_W);
   localparam logic [15:0] FULL_LFSR  = FULL_EXH - 16'd1;
   localparam logic [15:0] DRAIN_LOAD = 16'(RESP_LAT > 0 ? RESP_LAT - 1 : 0);

   state_t           state, state_nxt;
   logic             mode_q;
   logic [15:0]      remain;
   logic [15:0]      n_total;
   logic [IN_W-1:0]  first_pat, next_pat;
   logic             start_ok, run_now, sample_en, done_entry;
   logic [SIG_W-1:0] sig_nxt;

   assign start_ok   = start && !abort && (state == ST_IDLE || state == ST_DONE);
   assign run_now    = (state == ST_RUN);
   assign busy       = run_now || (state == ST_DRAIN);
   assign done       = (state == ST_DONE);
   assign done_entry = (state_nxt == ST_DONE) && busy;

   always_comb begin
      n_total = pat_count;
      if (pat_count == 16'd0) begin
         n_total = (mode == MODE_LFSR) ? FULL_LFSR : FULL_EXH;
      end
      first_pat = '0;
      if (mode == MODE_LFSR) begin
         first_pat = (seed == '0) ? IN_W'(1) : seed;
      end
      next_pat = dut_in + IN_W'(1);
      if (mode_q == MODE_LFSR) begin
         next_pat = (dut_in >> 1) ^ (dut_in[0] ? LFSR_TAPS : '0);
      end
   end

   // remain counts patterns still to apply in RUN, then drain cycles left in DRAIN
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_RUN;
            ST_RUN:   if (remain == 16'd0) state_nxt = (RESP_LAT == 0) ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (remain == 16'd0) state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dut_in   <= '0;
         remain   <= '0;
         mode_q   <= MODE_EXH;
         pass     <= 1'b0;
         ones_cnt <= '0;
      end else begin
         if (start_ok) begin
            dut_in <= first_pat;
            remain <= n_total - 16'd1;
            mode_q <= mode;
         end else if (!abort && run_now) begin
            if (remain == 16'd0) begin
               remain <= DRAIN_LOAD;
            end else begin
               remain <= remain - 16'd1;
               dut_in <= next_pat;
            end
         end else if (!abort && state == ST_DRAIN && remain != 16'd0) begin
            remain <= remain - 16'd1;
         end

         if (abort || start_ok) begin
            pass <= 1'b0;
         end else if (done_entry) begin
            pass <= (sig_nxt == exp_sig);
         end

         if (start_ok) begin
            ones_cnt <= '0;
         end else if (sample_en && !abort && dut_out && ones_cnt != 16'hFFFF) begin
            ones_cnt <= ones_cnt + 16'd1;
         end
      end
   end

   // valid pipeline aligns sampling with a DUT of RESP_LAT cycles latency
   generate
      if (RESP_LAT == 0) begin : g_lat0
         assign sample_en = run_now;
      end else begin : g_latn
         logic [RESP_LAT-1:0] vsr;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vsr <= '0;
            end else if (abort) begin
               vsr <= '0;
            end else begin
               vsr[0] <= run_now;
               for (int i = 1; i < RESP_LAT; i++) begin
                  vsr[i] <= vsr[i-1];
               end
            end
         end
         assign sample_en = vsr[RESP_LAT-1];
      end
   endgenerate

   ezpz_misr #(
      .SIG_W     (SIG_W),
      .MISR_POLY (MISR_POLY)
   ) u_misr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (start_ok),
      .enable  (sample_en && !abort),
      .din     (dut_out),
      .sig     (signature),
      .sig_nxt (sig_nxt)
   );

endmodule

// File: tb/tb_ezpz_bist_driver.sv
// tb/tb_ezpz_bist_driver.sv - bench for ezpz_bist_driver (combinational and 2-cycle-latency builds)
module tb_ezpz_bist_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, abort, mode;
   logic [9:0]  seed;
   logic [15:0] pat_count, exp_sig;

   logic [9:0]  dut_in1, dut_in2;
   logic        dut_out1, dut_out2;
   logic        busy1, done1, pass1, busy2, done2, pass2;
   logic [15:0] sig1, sig2, ones1, ones2;

   logic [1023:0] tt;
   int            cur_sel;
   logic [9:0]    d1, d2;
   logic [9:0]    plog[$];
   logic [9:0]    mq[$];
   bit            seen[1024];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   function automatic logic resp(input int sel, input logic [9:0] p);
      case (sel)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return p[0];
         default: return tt[p];
      endcase
   endfunction

   assign dut_out1 = resp(cur_sel, dut_in1);
   assign dut_out2 = resp(cur_sel, d2);

   always @(posedge clk) begin
      d1 <= dut_in2;
      d2 <= d1;
   end

   ezpz_bist_driver dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
      .seed(seed), .pat_count(pat_count), .exp_sig(exp_sig),
      .dut_in(dut_in1), .dut_out(dut_out1), .busy(busy1), .done(done1),
      .pass(pass1), .signature(sig1), .ones_cnt(ones1)
   );

   ezpz_bist_driver #(.RESP_LAT(2)) dut_lat (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
      .seed(seed), .pat_count(pat_count), .exp_sig(exp_sig),
      .dut_in(dut_in2), .dut_out(dut_out2), .busy(busy2), .done(done2),
      .pass(pass2), .signature(sig2), .ones_cnt(ones2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // reference: list the patterns from the sequencing rules, then fold responses into a signature
   task automatic model(input logic m, input logic [9:0] sd, input logic [15:0] pc, input int sel,
                        output logic [15:0] esig, output logic [15:0] eones, output int n);
      logic [9:0] p;
      logic       b;
      int         ones;
      n = (pc != 0) ? int'(pc) : (m ? 1023 : 1024);
      mq.delete();
      p = (sd == 10'd0) ? 10'd1 : sd;
      for (int k = 0; k < n; k++) begin
         if (m) begin
            mq.push_back(p);
            p = (p >> 1) ^ (p[0] ? 10'h240 : 10'h000);
         end else begin
            mq.push_back(10'(k % 1024));
         end
      end
      esig = 16'h0;
      ones = 0;
      foreach (mq[k]) begin
         b = resp(sel, mq[k]);
         esig = {esig[14:0], 1'b0} ^ (esig[15] ? 16'h1021 : 16'h0000) ^ {15'd0, b};
         ones += int'(b);
      end
      eones = (ones > 65535) ? 16'hFFFF : 16'(ones);
   endtask

   task automatic run_one(input logic m, input logic [9:0] sd, input logic [15:0] pc,
                          input logic [15:0] es, input int sel, output int c1, output int c2);
      int c;
      @(negedge clk);
      mode = m; seed = sd; pat_count = pc; exp_sig = es; cur_sel = sel; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      plog.delete();
      c1 = -1; c2 = -1; c = 0;
      chk("start_sig_clear", sig1, 16'h0);
      chk("start_ones_clear", ones1, 16'h0);
      while ((c1 < 0 || c2 < 0) && c < 2200) begin
         if (busy1) plog.push_back(dut_in1);
         if (c1 < 0 && done1) c1 = c;
         if (c2 < 0 && done2) c2 = c;
         @(negedge clk);
         c++;
      end
      if (c1 < 0 || c2 < 0) chk("done_timeout", 32'(c), 32'(0));
   endtask

   typedef struct {
      logic        m;
      logic [9:0]  sd;
      logic [15:0] pc;
      logic [15:0] es;
      int          sel;
      logic [15:0] xsig;
      logic [15:0] xones;
      int          xcyc;
      logic        xpass;
   } vec_t;

   vec_t tbl[5];

   initial begin
      logic [15:0] esig, eones, sb, ob;
      int          n, c1, c2, nd, lerr;
      logic        m;
      logic [9:0]  sd;
      logic [15:0] pc;

      tbl[0] = '{1'b0, 10'd0,   16'd0, 16'h0000, 0, 16'h0000, 16'd0, 1024, 1'b1};
      tbl[1] = '{1'b0, 10'd0,   16'd4, 16'h0006, 2, 16'h0005, 16'd2, 4,    1'b0};
      tbl[2] = '{1'b0, 10'd0,   16'd2, 16'h0003, 1, 16'h0003, 16'd2, 2,    1'b1};
      tbl[3] = '{1'b1, 10'd0,   16'd0, 16'h0000, 0, 16'h0000, 16'd0, 1023, 1'b1};
      tbl[4] = '{1'b1, 10'h3ff, 16'd3, 16'h0007, 1, 16'h0007, 16'd3, 3,    1'b1};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
      seed = '0; pat_count = '0; exp_sig = '0; cur_sel = 0; tt = '0;
      repeat (3) @(negedge clk);
      chk("rst_dut_in", dut_in1, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_pass", pass1, 0);
      chk("rst_sig", sig1, 0);
      chk("rst_ones", ones1, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_one(tbl[i].m, tbl[i].sd, tbl[i].pc, tbl[i].es, tbl[i].sel, c1, c2);
         chk($sformatf("v%0d_cycles", i), c1, tbl[i].xcyc);
         chk($sformatf("v%0d_cycles_lat2", i), c2, tbl[i].xcyc + 2);
         chk($sformatf("v%0d_sig", i), sig1, tbl[i].xsig);
         chk($sformatf("v%0d_sig_lat2", i), sig2, tbl[i].xsig);
         chk($sformatf("v%0d_ones", i), ones1, tbl[i].xones);
         chk($sformatf("v%0d_ones_lat2", i), ones2, tbl[i].xones);
         chk($sformatf("v%0d_pass", i), pass1, tbl[i].xpass);
         chk($sformatf("v%0d_pass_lat2", i), pass2, tbl[i].xpass);
         if (i == 1) begin
            chk("v1_len", plog.size(), 4);
            if (plog.size() == 4)
               for (int j = 0; j < 4; j++) chk($sformatf("v1_pat%0d", j), plog[j], j);
         end
         if (i == 3) begin
            for (int j = 0; j < 1024; j++) seen[j] = 1'b0;
            nd = 0;
            foreach (plog[j]) if (!seen[plog[j]]) begin seen[plog[j]] = 1'b1; nd++; end
            chk("lfsr_len", plog.size(), 1023);
            chk("lfsr_distinct", nd, 1023);
            chk("lfsr_no_zero", seen[0], 0);
            if (plog.size() >= 2) begin
               chk("lfsr_first", plog[0], 10'h001);
               chk("lfsr_second", plog[1], 10'h240);
            end
            chk("hold_last_pat", dut_in1, plog[plog.size()-1]);
         end
      end

      for (int r = 0; r < 6; r++) begin
         for (int w = 0; w < 32; w++) tt[w*32 +: 32] = $urandom();
         m  = 1'($urandom_range(0, 1));
         sd = 10'($urandom_range(0, 1023));
         case ($urandom_range(0, 3))
            0:       pc = 16'd0;
            1:       pc = 16'd1030;
            default: pc = 16'($urandom_range(1, 300));
         endcase
         model(m, sd, pc, 3, esig, eones, n);
         if (r[0]) esig = esig ^ 16'h0001;
         run_one(m, sd, pc, esig, 3, c1, c2);
         if (r[0]) esig = esig ^ 16'h0001;
         lerr = (plog.size() == mq.size()) ? 0 : 1;
         if (lerr == 0) foreach (mq[j]) if (plog[j] !== mq[j]) lerr++;
         chk($sformatf("r%0d_patterns", r), lerr, 0);
         chk($sformatf("r%0d_cycles", r), c1, n);
         chk($sformatf("r%0d_cycles_lat2", r), c2, n + 2);
         chk($sformatf("r%0d_sig", r), sig1, esig);
         chk($sformatf("r%0d_sig_lat2", r), sig2, esig);
         chk($sformatf("r%0d_ones", r), ones1, eones);
         chk($sformatf("r%0d_ones_lat2", r), ones2, eones);
         chk($sformatf("r%0d_pass", r), pass1, !r[0]);
         chk($sformatf("r%0d_pass_lat2", r), pass2, !r[0]);
      end

      // abort ten cycles into a 100-pattern run
      for (int w = 0; w < 32; w++) tt[w*32 +: 32] = $urandom();
      @(negedge clk);
      mode = 1'b0; pat_count = 16'd100; cur_sel = 3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      sb = sig1; ob = ones1;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", busy1, 0);
      chk("abort_done", done1, 0);
      chk("abort_sig_hold", sig1, sb);
      chk("abort_ones_hold", ones1, ob);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("start_abort_same_edge", busy1, 0);
      model(1'b0, 10'd0, 16'd100, 3, esig, eones, n);
      run_one(1'b0, 10'd0, 16'd100, esig, 3, c1, c2);
      chk("restart_first_pat", (plog.size() > 0) ? plog[0] : 10'h3ff, 0);
      chk("restart_sig", sig1, esig);
      chk("restart_ones", ones1, eones);
      chk("restart_pass", pass1, 1);

      // asynchronous reset between edges mid-run
      @(negedge clk);
      mode = 1'b1; seed = 10'd5; pat_count = 16'd200; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_dut_in", dut_in1, 0);
      chk("arst_busy", busy1, 0);
      chk("arst_done", done1, 0);
      chk("arst_sig", sig1, 0);
      chk("arst_ones", ones1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model(1'b1, 10'd5, 16'd200, 3, esig, eones, n);
      run_one(1'b1, 10'd5, 16'd200, esig, 3, c1, c2);
      chk("post_rst_cycles", c1, n);
      chk("post_rst_sig", sig1, esig);
      chk("post_rst_ones", ones1, eones);
      chk("post_rst_pass", pass1, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
